// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one 48-bit SPI master between two requesters.
// Round-robin grant, one-cycle start pulse, level-done completion detection,
// watchdog abort and a guard gap between frames.
//
// Request/ack handshake: a requester raises reqN_i with its frame, divider
// and bit order stable, and holds them until ackN_o. ackN_o is high for
// exactly one cycle per granted transaction, and rdata_o/err_o are valid in
// that cycle. Dropping reqN_i after the grant does not cancel the transaction.
module spi_txn_arbiter #(
  parameter int TIMEOUT    = 4096,
  parameter int GAP_CYCLES = 8,
  parameter int TO_W       = 13
) (
  input  logic        spi_clk_i,
  input  logic        spi_rst_i,
  input  logic        req0_i,
  input  logic [47:0] req0_data_i,
  input  logic [1:0]  req0_div_i,
  input  logic        req0_fbo_i,
  input  logic        req1_i,
  input  logic [47:0] req1_data_i,
  input  logic [1:0]  req1_div_i,
  input  logic        req1_fbo_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic [47:0] rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        m_start_o,
  output logic [47:0] m_data_o,
  output logic [1:0]  m_div_o,
  output logic        m_fbo_o,
  input  logic        m_done_i,
  input  logic [47:0] m_rdata_i,
  output logic [2:0]  state_dbg_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  state_t           r_state;
  state_t           w_next;
  logic [TO_W-1:0]  r_to_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_done_q;
  logic             r_last_grant;
  logic             r_grant_id;
  logic             w_req_any;
  logic             w_pick;
  logic             w_rise;
  logic             w_timeout;
  logic             w_gap_end;

  assign w_req_any   = req0_i | req1_i;
  // With both requesting, the one that did not win last time goes next.
  assign w_pick      = (req0_i & req1_i) ? ~r_last_grant : req1_i;
  assign w_rise      = m_done_i & ~r_done_q;
  assign w_timeout   = (r_to_cnt == TO_W'(TIMEOUT));
  assign w_gap_end   = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign state_dbg_o = r_state;

  // State register.
  always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
    if (!spi_rst_i) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next    = r_state;
    m_start_o = 1'b0;
    busy_o    = 1'b1;
    ack0_o    = 1'b0;
    ack1_o    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (w_req_any) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        m_start_o = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (w_rise || w_timeout) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        ack0_o = ~r_grant_id;
        ack1_o = r_grant_id;
        w_next = S_GAP;
      end
      S_GAP: begin
        if (w_gap_end) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Grant latching, watchdog, done-edge tracking, result capture and gap count.
  always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
    if (!spi_rst_i) begin
      m_data_o     <= '0;
      m_div_o      <= '0;
      m_fbo_o      <= 1'b0;
      rdata_o      <= '0;
      err_o        <= 1'b0;
      r_to_cnt     <= '0;
      r_gap_cnt    <= '0;
      r_done_q     <= 1'b0;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_grant_id <= w_pick;
            m_data_o   <= w_pick ? req1_data_i : req0_data_i;
            m_div_o    <= w_pick ? req1_div_i  : req0_div_i;
            m_fbo_o    <= w_pick ? req1_fbo_i  : req0_fbo_i;
            err_o      <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_to_cnt <= '0;
          // Preset so a done level left over from the previous frame cannot
          // look like a rise; a low must be seen in WAIT first.
          r_done_q <= 1'b1;
        end
        S_WAIT: begin
          r_done_q <= m_done_i;
          r_to_cnt <= r_to_cnt + TO_W'(1);
          if (w_rise) begin
            rdata_o <= m_rdata_i;
            err_o   <= 1'b0;
          end else if (w_timeout) begin
            rdata_o <= '1;
            err_o   <= 1'b1;
          end
        end
        S_CAPTURE: begin
          r_last_grant <= r_grant_id;
          r_gap_cnt    <= '0;
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: directed vector table, hand-written
// corner sequences and randomized transactions against a behavioural model.
`timescale 1ns/1ps
module tb_spi_txn_arbiter;

  localparam int TIMEOUT    = 256;
  localparam int GAP_CYCLES = 8;
  localparam int TO_W       = 13;
  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req0 = 1'b0, req1 = 1'b0;
  logic [47:0] d0 = '0, d1 = '0;
  logic [1:0]  v0 = '0, v1 = '0;
  logic        f0 = 1'b0, f1 = 1'b0;
  logic        ack0, ack1, err, busy, m_start, m_fbo;
  logic [47:0] rdata, m_data, m_rdata;
  logic [1:0]  m_div;
  logic        m_done = 1'b0;
  logic [2:0]  state_dbg;

  spi_txn_arbiter #(.TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES), .TO_W(TO_W)) u_dut (
    .spi_clk_i(clk), .spi_rst_i(rst_n),
    .req0_i(req0), .req0_data_i(d0), .req0_div_i(v0), .req0_fbo_i(f0),
    .req1_i(req1), .req1_data_i(d1), .req1_div_i(v1), .req1_fbo_i(f1),
    .ack0_o(ack0), .ack1_o(ack1), .rdata_o(rdata), .err_o(err), .busy_o(busy),
    .m_start_o(m_start), .m_data_o(m_data), .m_div_o(m_div), .m_fbo_o(m_fbo),
    .m_done_i(m_done), .m_rdata_i(m_rdata), .state_dbg_o(state_dbg)
  );

  // ---------------- SPI master model ----------------
  // done level as a function of cycles since the start pulse (cycle 0):
  // held high before cycle 'drop' (stale level), high from cycle 'lat' on.
  function automatic bit wave(int c, int lat, int drop);
    return (drop > 0 && c < drop) || (lat >= 0 && c >= lat);
  endfunction

  int          cfg_lat = -1;
  int          cfg_drop = 0;
  logic [47:0] cfg_rd = '0;
  int          mc = -1;

  always begin
    @(posedge clk); #1;
    if (m_start) mc = 0;
    else if (mc >= 0) mc++;
    if (mc >= 0) m_done = wave(mc, cfg_lat, cfg_drop);
  end
  assign m_rdata = m_done ? cfg_rd : ~cfg_rd;

  // ---------------- reference model ----------------
  // The transfer window opens the cycle after the start pulse and lasts
  // TIMEOUT+1 cycles; completion is the first low-to-high of done seen inside
  // it, answered one cycle later. Without one the watchdog answers at TIMEOUT+2.
  task automatic predict(input int lat, input int drop, output int at, output bit abort);
    at = TIMEOUT + 2;
    abort = 1'b1;
    for (int c = 2; c <= TIMEOUT + 1; c++)
      if (abort && wave(c, lat, drop) && !wave(c - 1, lat, drop)) begin
        at = c + 1;
        abort = 1'b0;
      end
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int g_start_cyc = 0;
  int g_ack_cyc = 0;
  int last_model = 1;
  logic [47:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ack0"}, ack0, 0);
    check({tag, "_ack1"}, ack1, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, m_start, 0);
    check({tag, "_mdata"}, m_data, 0);
    check({tag, "_mdiv"}, m_div, 0);
    check({tag, "_mfbo"}, m_fbo, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // ---------------- driver / transaction checker ----------------
  // Requests are already applied. Waits for the start pulse, checks the
  // frame handed to the master, waits for the ack and checks result, pulse
  // width and guard gap. Returns in the first idle cycle after the gap.
  task automatic txn(input int exp_id, input logic [47:0] exp_d, input logic [1:0] exp_v,
                     input logic exp_f, input int exp_at, input logic [47:0] exp_rd,
                     input logic exp_e, input bit keep, input int drop_at);
    int c, n_start, n_unstable, g;
    c = 0;
    while (!m_start && c < 30) begin step(); c++; end
    check("start_seen", m_start, 1'b1);
    g_start_cyc = cyc;
    check("m_data", m_data, exp_d);
    check("m_div", m_div, exp_v);
    check("m_fbo", m_fbo, exp_f);
    check("err_clear_on_grant", err, 1'b0);
    n_start = 0; n_unstable = 0; c = 0;
    while (!(ack0 || ack1) && c < TIMEOUT + 40) begin
      step(); c++;
      if (c == drop_at) begin req0 = 1'b0; req1 = 1'b0; end
      if (m_start) n_start++;
      if (m_data !== exp_d || m_div !== exp_v || m_fbo !== exp_f) n_unstable++;
    end
    g_ack_cyc = cyc;
    exp_q.push_back(exp_rd);
    check("extra_start", n_start, 0);
    check("frame_stable", n_unstable, 0);
    check("ack_latency", c, exp_at);
    check("ack_id", {ack1, ack0}, (exp_id == 0) ? 2'b01 : 2'b10);
    check("rdata", rdata, exp_q.pop_front());
    check("err", err, exp_e);
    step();
    check("ack_one_cycle", {ack1, ack0}, 2'b00);
    check("rdata_held", rdata, exp_rd);
    if (!keep) begin req0 = 1'b0; req1 = 1'b0; end
    g = 0;
    while (busy && g < 40) begin g++; step(); end
    check("gap_len", g, GAP_CYCLES);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r0, r1;
    logic [47:0] d0, d1;
    logic [1:0]  v0, v1;
    logic        f0, f1;
    int          lat, drop;
    logic [47:0] rd;
    int          exp_id, exp_at;
    logic [47:0] exp_rd;
    logic        exp_e;
  } vec_t;

  vec_t tbl[9];

  // ---------------- test sequence ----------------
  initial begin
    int at, p, w, sel, lat, drop, n_ack, n_st;
    bit ab;
    logic [47:0] rd;

    // req0 only, slow master: the basic read
    tbl[0] = '{1'b1, 1'b0, 48'hA5A5_0000_1234, 48'h0, 2'b01, 2'b00, 1'b1, 1'b0,
               200, 0, 48'h0000_0000_BEEF, 0, 201, 48'h0000_0000_BEEF, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 48'h0, 48'h1111_2222_3333, 2'b00, 2'b10, 1'b0, 1'b0,
               10, 0, 48'h1234_5678_9ABC, 1, 11, 48'h1234_5678_9ABC, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 48'h0F0F_0F0F_0F0F, 48'hF0F0_F0F0_F0F0, 2'b11, 2'b00, 1'b0, 1'b1,
               5, 0, 48'hCAFE_0000_0001, 0, 6, 48'hCAFE_0000_0001, 1'b0};
    // master never finishes: watchdog abort
    tbl[3] = '{1'b1, 1'b1, 48'h0000_0000_0001, 48'h8000_0000_0000, 2'b00, 2'b01, 1'b1, 1'b1,
               -1, 0, 48'h0, 1, TIMEOUT + 2, ONES, 1'b1};
    // quickest possible completion; also clears the previous error
    tbl[4] = '{1'b1, 1'b0, 48'h5555_AAAA_5555, 48'h0, 2'b10, 2'b00, 1'b0, 1'b0,
               2, 0, 48'h0000_0000_0002, 0, 3, 48'h0000_0000_0002, 1'b0};
    // stale done high across the start, drops at 3, real rise at 50
    tbl[5] = '{1'b1, 1'b1, 48'h0000_0000_0001, 48'h3C3C_3C3C_3C3C, 2'b00, 2'b11, 1'b0, 1'b0,
               50, 3, 48'hDEAD_BEEF_0050, 1, 51, 48'hDEAD_BEEF_0050, 1'b0};
    // rise in the last watch cycle still counts as completion
    tbl[6] = '{1'b1, 1'b0, 48'h7777_0000_7777, 48'h0, 2'b01, 2'b00, 1'b1, 1'b0,
               TIMEOUT + 1, 0, 48'h0000_0000_0101, 0, TIMEOUT + 2, 48'h0000_0000_0101, 1'b0};
    // one cycle later is a timeout
    tbl[7] = '{1'b0, 1'b1, 48'h0, 48'h0000_FFFF_0000, 2'b00, 2'b00, 1'b0, 1'b0,
               TIMEOUT + 2, 0, 48'h0000_0000_0123, 1, TIMEOUT + 2, ONES, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 48'h2468_ACE0_1357, 48'h9999_9999_9999, 2'b10, 2'b01, 1'b1, 1'b0,
               3, 0, 48'h0000_0000_ABCD, 0, 4, 48'h0000_0000_ABCD, 1'b0};

    // reset state
    repeat (2) step();
    check_quiet("reset");
    rst_n = 1'b1;
    step();
    check_quiet("post_reset_idle");

    for (int i = 0; i < 9; i++) begin
      cfg_lat = tbl[i].lat; cfg_drop = tbl[i].drop; cfg_rd = tbl[i].rd;
      d0 = tbl[i].d0; d1 = tbl[i].d1; v0 = tbl[i].v0; v1 = tbl[i].v1;
      f0 = tbl[i].f0; f1 = tbl[i].f1;
      req0 = tbl[i].r0; req1 = tbl[i].r1;
      txn(tbl[i].exp_id, (tbl[i].exp_id == 0) ? tbl[i].d0 : tbl[i].d1,
          (tbl[i].exp_id == 0) ? tbl[i].v0 : tbl[i].v1,
          (tbl[i].exp_id == 0) ? tbl[i].f0 : tbl[i].f1,
          tbl[i].exp_at, tbl[i].exp_rd, tbl[i].exp_e, 1'b0, -1);
      last_model = tbl[i].exp_id;
    end

    // both requesters held from reset: strict alternation with full gaps
    #3 rst_n = 1'b0;
    d0 = 48'h0000_1111_0000; v0 = 2'b01; f0 = 1'b1;
    d1 = 48'h2222_0000_2222; v1 = 2'b10; f1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    last_model = 1;
    for (int k = 0; k < 4; k++) begin
      int prev_ack;
      prev_ack = g_ack_cyc;
      w = (last_model == 0) ? 1 : 0;
      cfg_lat = $urandom_range(5, 30); cfg_drop = 0; cfg_rd = {16'($urandom), 32'($urandom)};
      predict(cfg_lat, cfg_drop, at, ab);
      txn(w, w ? d1 : d0, w ? v1 : v0, w ? f1 : f0, at, cfg_rd, 1'b0, 1'b1, -1);
      check("alternate_grant", w, k % 2);
      if (k > 0) check("ack_to_next_start", g_start_cyc - prev_ack, GAP_CYCLES + 2);
      last_model = w;
    end
    req0 = 1'b0; req1 = 1'b0;
    step();

    // reset in the middle of a req1 transfer
    d1 = 48'h0BAD_0BAD_0BAD; v1 = 2'b11; f1 = 1'b1;
    cfg_lat = 100; cfg_drop = 0; cfg_rd = 48'h0000_0000_1111;
    req1 = 1'b1;
    n_st = 0;
    while (!m_start && n_st < 30) begin step(); n_st++; end
    check("t5_start_seen", m_start, 1'b1);
    repeat (10) step();
    check("t5_busy_before_reset", busy, 1'b1);
    #3 rst_n = 1'b0;
    #1 check_quiet("async_reset");
    n_ack = 0;
    for (int k = 0; k < 5; k++) begin step(); if (ack0 || ack1) n_ack++; end
    check("t5_no_ack_in_reset", n_ack, 0);
    rst_n = 1'b1;
    req1 = 1'b0;
    last_model = 1;
    d0 = 48'h0000_0000_0D0D; v0 = 2'b10; f0 = 1'b0;
    cfg_lat = 20; cfg_rd = 48'h5A5A_5A5A_5A5A;
    req0 = 1'b1; req1 = 1'b1;
    txn(0, d0, v0, f0, 21, cfg_rd, 1'b0, 1'b0, -1);
    last_model = 0;

    // req1 withdraws mid-transfer: still one ack, no regrant
    d1 = 48'h6666_7777_8888; v1 = 2'b01; f1 = 1'b0;
    cfg_lat = 60; cfg_rd = 48'h0000_0060_0060;
    req1 = 1'b1;
    txn(1, d1, v1, f1, 61, cfg_rd, 1'b0, 1'b0, 11);
    last_model = 1;
    n_st = 0;
    for (int k = 0; k < 20; k++) begin step(); if (m_start || busy) n_st++; end
    check("t6_no_regrant", n_st, 0);

    // randomized transactions against the reference model
    for (int it = 0; it < 30; it++) begin
      p = $urandom_range(1, 3);
      w = (p == 3) ? ((last_model == 0) ? 1 : 0) : ((p == 1) ? 0 : 1);
      d0 = {16'($urandom), 32'($urandom)}; d1 = {16'($urandom), 32'($urandom)};
      v0 = 2'($urandom); v1 = 2'($urandom); f0 = 1'($urandom); f1 = 1'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        lat = $urandom_range(2, 120); drop = 0;
      end else if (sel < 8) begin
        drop = $urandom_range(1, 6); lat = drop + $urandom_range(1, 40);
      end else begin
        lat = (sel == 8) ? -1 : $urandom_range(TIMEOUT - 6, TIMEOUT + 6); drop = 0;
      end
      rd = {16'($urandom), 32'($urandom)};
      cfg_lat = lat; cfg_drop = drop; cfg_rd = rd;
      predict(lat, drop, at, ab);
      req0 = p[0]; req1 = p[1];
      txn(w, w ? d1 : d0, w ? v1 : v0, w ? f1 : f0, at, ab ? ONES : rd, ab, 1'b0, -1);
      last_model = w;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "time limit");
  end

endmodule
